// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external 8-bit combinational ALU between two requesters.
//   An op is accepted in IDLE, its operands are latched and held on alu_*,
//   the ALU outputs are captured one cycle later (EXEC), and the captured
//   result is presented to the owning requester until it takes it (RESP).
//   On response completion priority passes to the other requester.
//
// Handshake semantics (both request and response channels):
//   a transfer happens on a rising clk edge where valid and ready are both
//   1 for the same bit. valid may be raised or dropped freely before the
//   transfer; ready never depends on a transfer in the same cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester op handshake
//   req_a/req_b [15:0]         {X1,X0} 8-bit operands per requester
//   req_sel [7:0]              {SEL1,SEL0} 4-bit opcodes per requester
//   rsp_valid/rsp_ready [1:0]  per-requester result handshake
//   rsp_result/carry/zero      captured ALU outputs
//   rsp_illegal                captured opcode was 4'hD..4'hF
//   alu_a/alu_b/alu_sel        held operands to the shared ALU
//   alu_out/carry/zero         ALU outputs (combinational from alu_*)
//   busy                       FSM not in IDLE
//   op_count [15:0]            completed operations (wraps)
module alu_arbiter #(
  parameter int FIRST_PRI = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_sel,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_illegal,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic PRI_RST = (FIRST_PRI != 0);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        pri_q, pri_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  result_q, result_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        illegal_q, illegal_d;
  logic [15:0] op_count_q, op_count_d;

  logic gnt;
  logic accept;
  logic rsp_fire;

  // Grant: the lone valid requester, or the priority holder on contention.
  assign gnt = (req_valid == 2'b11) ? pri_q : req_valid[1];

  // rst_n is folded in so ready is 0 while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == ST_IDLE && rst_n && (req_valid != 2'b00)) begin
      req_ready = gnt ? 2'b10 : 2'b01;
    end
  end

  assign accept   = |(req_valid & req_ready);
  // Only the owner's ready bit matters; the other bit is don't-care.
  assign rsp_fire = (state_q == ST_RESP) && rsp_ready[owner_q];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    pri_d      = pri_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    illegal_d  = illegal_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = gnt;
          a_d     = gnt ? req_a[15:8]  : req_a[7:0];
          b_d     = gnt ? req_b[15:8]  : req_b[7:0];
          sel_d   = gnt ? req_sel[7:4] : req_sel[3:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d  = alu_out;
        carry_d   = alu_carry;
        zero_d    = alu_zero;
        illegal_d = (sel_q >= 4'b1101);
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          pri_d      = ~owner_q;
          op_count_d = op_count_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      pri_q      <= PRI_RST;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      sel_q      <= 4'h0;
      result_q   <= 8'h00;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
      op_count_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      pri_q      <= pri_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
      op_count_q <= op_count_d;
    end
  end

  assign rsp_valid   = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result  = result_q;
  assign rsp_carry   = carry_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = illegal_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_sel     = sel_q;
  assign busy        = (state_q != ST_IDLE);
  assign op_count    = op_count_q;

endmodule
